// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - buffered 8N1 UART transmitter: byte FIFO feeding a bit serializer
module uart_tx_fifo #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200,
  parameter int DEPTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [7:0]               data,
  input  logic                     valid,
  output logic                     ready,
  output logic                     tx,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  generate
    if (DIV < 2) begin : g_div_check
      $fatal(1, "uart_tx_fifo: CLK_FREQ/BAUD must be at least 2");
    end
    if (DEPTH < 2 || (1 << AW) != DEPTH) begin : g_depth_check
      $fatal(1, "uart_tx_fifo: DEPTH must be a power of 2 and at least 2");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            tx_q, tx_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [7:0]      fifo_mem [DEPTH];

  logic push;
  logic pop;
  logic baud_last;
  logic fifo_nonempty;

  assign ready         = (count_q != FULL_CNT);
  assign busy          = (state_q != IDLE) || (count_q != '0);
  assign level         = count_q;
  assign tx            = tx_q;
  assign push          = valid && ready;
  assign baud_last     = (cnt_q == CNT_LAST);
  assign fifo_nonempty = (count_q != '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (fifo_nonempty) begin
          pop     = 1'b1;
          shift_d = fifo_mem[rd_ptr_q];
          state_d = START;
        end
      end
      START: begin
        if (baud_last) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (baud_last) begin
          cnt_d   = '0;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // Popping on the last stop cycle keeps back-to-back frames gapless.
        if (baud_last) begin
          cnt_d = '0;
          if (fifo_nonempty) begin
            pop     = 1'b1;
            shift_d = fifo_mem[rd_ptr_q];
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase

    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q + (AW + 1)'(push) - (AW + 1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= 1'b1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      tx_q     <= tx_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && push) fifo_mem[wr_ptr_q] <= data;
  end

endmodule
